// File: rtl/dino_pkg.sv
// Shared definitions for the dino game input path: PS/2 scan-code
// constants, parser state encoding and the held-key flag record.
package dino_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_ENTER = 8'h5A;

   typedef enum logic [1:0] {
      PS_IDLE    = 2'd0,
      PS_EXT     = 2'd1,
      PS_BRK     = 2'd2,
      PS_EXT_BRK = 2'd3
   } parse_state_t;

   typedef struct packed {
      logic sp;   // space
      logic ua;   // extended up arrow
      logic da;   // extended down arrow
      logic en;   // enter
   } held_t;

   // Apply one make/break to the held flags; unmapped codes fall through untouched.
   // Keypad 75/72 (not extended) deliberately do not touch the arrow flags.
   function automatic held_t key_update(input held_t h, input logic ext,
                                        input logic make, input logic [7:0] code);
      held_t r;
      r = h;
      if (!ext && code == SC_SPACE) r.sp = make;
      if (!ext && code == SC_ENTER) r.en = make;
      if (ext && code == SC_UP)     r.ua = make;
      if (ext && code == SC_DOWN)   r.da = make;
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// PS/2 pins plus the dino command outputs of ps2_key_ctrl.
// master: the key controller; slave: the pin driver / command consumer.
interface ps2_key_ctrl_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       up;
   logic       down;
   logic       start;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_err;

   modport master (
      input  ps2_clk, ps2_data,
      output up, down, start, scan_code, scan_valid, frame_err
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  up, down, start, scan_code, scan_valid, frame_err
   );
endinterface

// File: rtl/ps2_key_ctrl_rx.sv
// ps2_rx: PS/2 receive front end. Synchronizes both pins, glitch-filters
// the clock, shifts 11-bit frames on filtered falling edges and checks
// start/stop/odd parity. Optional mid-frame watchdog under PS2_TIMEOUT_EN.
module ps2_rx #(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FILT_W-1:0] FILT_LOAD = FILT_W'(FILT_LEN - 1);

   logic              clk_s1, clk_s2, dat_s1, dat_s2;
   logic              filt_clk;
   logic [FILT_W-1:0] filt_cnt;
   logic              fall;
   logic [3:0]        bit_cnt;
   logic [9:0]        shreg;
   logic              frame_good;
   logic              to_fire;

   // two-flop synchronizers; idle bus level is high
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // filtered clock flips only after FILT_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_clk <= 1'b1;
         filt_cnt <= FILT_LOAD;
      end else if (clk_s2 == filt_clk) begin
         filt_cnt <= FILT_LOAD;
      end else if (filt_cnt == '0) begin
         filt_clk <= clk_s2;
         filt_cnt <= FILT_LOAD;
      end else begin
         filt_cnt <= filt_cnt - 1'b1;
      end
   end

   assign fall = filt_clk & ~clk_s2 & (filt_cnt == '0);

   // after 10 shifts: shreg[0]=start, shreg[8:1]=data, shreg[9]=parity; stop is live
   assign frame_good = ~shreg[0] & dat_s2 & (^shreg[9:1]);

`ifdef PS2_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] to_cnt;

   // watchdog counts idle cycles inside a frame, re-armed by every falling edge
   always_ff @(posedge clk) begin
      if (rst || fall || bit_cnt == 4'd0) begin
         to_cnt <= TO_LOAD;
      end else if (to_cnt != '0) begin
         to_cnt <= to_cnt - 1'b1;
      end
   end

   assign to_fire = (bit_cnt != 4'd0) & (to_cnt == '0) & ~fall;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign to_fire = 1'b0;
`endif

   // frame shifter and good/bad frame strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt  <= 4'd0;
         shreg    <= '0;
         rx_byte  <= 8'h00;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         if (fall) begin
            if (bit_cnt == 4'd10) begin
               bit_cnt <= 4'd0;
               if (frame_good) begin
                  rx_byte  <= shreg[8:1];
                  rx_valid <= 1'b1;
               end else begin
                  rx_err <= 1'b1;
               end
            end else begin
               shreg   <= {dat_s2, shreg[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (to_fire) begin
            bit_cnt <= 4'd0;
            rx_err  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 keyboard to dino commands (up, down, start).
// Optional macro PS2_TIMEOUT_EN enables the mid-frame watchdog in ps2_rx.
//
//  state      | meaning
//  PS_IDLE    | no prefix pending; next byte is a plain make (or a prefix)
//  PS_EXT     | E0 seen; next byte is an extended make (or F0)
//  PS_BRK     | F0 seen; next byte is a plain break
//  PS_EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_key_ctrl
   import dino_pkg::*;
#(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic           clk_25MHz,
   input  logic           rst,
   ps2_key_ctrl_if.master bus
);

   logic [7:0]   rx_byte;
   logic         rx_valid;
   logic         rx_err;

   parse_state_t state, state_nxt;
   held_t        held, held_nxt;
   logic         start_nxt, up_nxt, down_nxt;
   logic         up_q, down_q, start_q;

   ps2_rx #(
      .FILT_LEN    (FILT_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk      (clk_25MHz),
      .rst      (rst),
      .ps2_clk  (bus.ps2_clk),
      .ps2_data (bus.ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   // prefix parsing and key-map update for each good byte
   always_comb begin
      state_nxt = state;
      held_nxt  = held;
      start_nxt = 1'b0;
      if (rx_valid) begin
         unique case (state)
            PS_IDLE: begin
               if (rx_byte == SC_EXT) begin
                  state_nxt = PS_EXT;
               end else if (rx_byte == SC_BRK) begin
                  state_nxt = PS_BRK;
               end else begin
                  held_nxt  = key_update(held, 1'b0, 1'b1, rx_byte);
                  start_nxt = (rx_byte == SC_ENTER) & ~held.en;
               end
            end
            PS_EXT: begin
               if (rx_byte == SC_BRK) begin
                  state_nxt = PS_EXT_BRK;
               end else begin
                  held_nxt  = key_update(held, 1'b1, 1'b1, rx_byte);
                  state_nxt = PS_IDLE;
               end
            end
            PS_BRK: begin
               held_nxt  = key_update(held, 1'b0, 1'b0, rx_byte);
               state_nxt = PS_IDLE;
            end
            PS_EXT_BRK: begin
               held_nxt  = key_update(held, 1'b1, 1'b0, rx_byte);
               state_nxt = PS_IDLE;
            end
            default: state_nxt = PS_IDLE;
         endcase
      end
      up_nxt   = held_nxt.sp | held_nxt.ua;
      down_nxt = held_nxt.da & ~up_nxt;
   end

   // parser state, held flags and registered command outputs
   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         state   <= PS_IDLE;
         held    <= '0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         held    <= held_nxt;
         up_q    <= up_nxt;
         down_q  <= down_nxt;
         start_q <= start_nxt;
      end
   end

   assign bus.up         = up_q;
   assign bus.down       = down_q;
   assign bus.start      = start_q;
   assign bus.scan_code  = rx_byte;
   assign bus.scan_valid = rx_valid;
   assign bus.frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a bit-level frame model and a
// make/break key model predict every scan_valid/frame_err event and the
// command levels that follow it; a monitor pops and compares.
module tb_ps2_key_ctrl;

   localparam int HALF = 12;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         up;
      bit         down;
      bit         start;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ps2_key_ctrl_if bus ();

   ps2_key_ctrl #(
      .FILT_LEN    (8),
      .TIMEOUT_CYC (50000)
   ) dut (
      .clk_25MHz (clk),
      .rst       (rst),
      .bus       (bus)
   );

   always #20 clk = ~clk;

   ev_t exp_q[$];
   ev_t cur_ev;
   bit  chk_pend = 1'b0;
   int  n_checks = 0;
   int  n_fail   = 0;
   int  n_start  = 0;
   bit  pend[$];
   bit  m_ext = 1'b0, m_brk = 1'b0;
   bit  h_sp = 1'b0, h_ua = 1'b0, h_da = 1'b0, h_en = 1'b0;
   bit  prev_err = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_up();
      return h_sp | h_ua;
   endfunction

   function automatic bit m_down();
      return h_da & ~(h_sp | h_ua);
   endfunction

   // keyboard protocol model: E0/F0 prefixes, then make or break of a key
   task automatic model_byte(input logic [7:0] b);
      ev_t e;
      bit  st;
      bit  mk;
      st = 1'b0;
      if (!m_brk && !m_ext && b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (!m_brk && b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         mk = !m_brk;
         if (!m_ext && b == 8'h29) h_sp = mk;
         if (!m_ext && b == 8'h5A) begin
            st   = mk && !h_en;
            h_en = mk;
         end
         if (m_ext && b == 8'h75) h_ua = mk;
         if (m_ext && b == 8'h72) h_da = mk;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      e.is_err = 1'b0;
      e.code   = b;
      e.up     = m_up();
      e.down   = m_down();
      e.start  = st;
      exp_q.push_back(e);
   endtask

   // receiver model: every 11 falling-edge bits form one frame
   task automatic model_bit(input bit b);
      int         ones;
      logic [7:0] d;
      ev_t        e;
      pend.push_back(b);
      if (pend.size() == 11) begin
         ones = 0;
         for (int i = 1; i <= 9; i++) ones += int'(pend[i]);
         for (int i = 0; i < 8; i++) d[i] = pend[i+1];
         if (pend[0] == 1'b0 && pend[10] == 1'b1 && (ones % 2) == 1) begin
            model_byte(d);
         end else begin
            e.is_err = 1'b1;
            e.code   = 8'h00;
            e.up     = 1'b0;
            e.down   = 1'b0;
            e.start  = 1'b0;
            exp_q.push_back(e);
         end
         pend.delete();
      end
   endtask

   task automatic send_bit(input bit b);
      bus.ps2_data = b;
      repeat (HALF) @(posedge clk);
      #1 bus.ps2_clk = 1'b0;
      model_bit(b);
      repeat (HALF) @(posedge clk);
      #1 bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(bits[i]);
      repeat (2 * HALF) @(posedge clk);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || chk_pend) && t < 4000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 4000) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d events still outstanding, expected 0", exp_q.size());
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("held_up", 8'(bus.up), 8'(m_up()));
      check("held_down", 8'(bus.down), 8'(m_down()));
   endtask

   task automatic model_reset();
      pend.delete();
      exp_q.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
      h_sp  = 1'b0;
      h_ua  = 1'b0;
      h_da  = 1'b0;
      h_en  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_up"}, 8'(bus.up), 8'h00);
      check({tag, "_down"}, 8'(bus.down), 8'h00);
      check({tag, "_start"}, 8'(bus.start), 8'h00);
      check({tag, "_scan_code"}, bus.scan_code, 8'h00);
      check({tag, "_scan_valid"}, 8'(bus.scan_valid), 8'h00);
      check({tag, "_frame_err"}, 8'(bus.frame_err), 8'h00);
   endtask

   // monitor: pop one expected event per DUT strobe, then check levels a cycle later
   always @(negedge clk) begin
      if (rst) begin
         chk_pend = 1'b0;
         prev_err = 1'b0;
      end else begin
         if (bus.start) n_start++;
         if (chk_pend) begin
            check("up", 8'(bus.up), 8'(cur_ev.up));
            check("down", 8'(bus.down), 8'(cur_ev.down));
            check("start", 8'(bus.start), 8'(cur_ev.start));
            chk_pend = 1'b0;
         end else if (bus.start) begin
            check("stray_start", 8'(bus.start), 8'h00);
         end
         if (bus.frame_err && prev_err) check("err_width", 8'(bus.frame_err), 8'h00);
         if (bus.scan_valid || bus.frame_err) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: got scan_valid=%0b frame_err=%0b code=%0h, expected none",
                        bus.scan_valid, bus.frame_err, bus.scan_code);
            end else begin
               cur_ev = exp_q.pop_front();
               check("frame_err", 8'(bus.frame_err), 8'(cur_ev.is_err));
               check("scan_valid", 8'(bus.scan_valid), 8'(!cur_ev.is_err));
               if (!cur_ev.is_err) begin
                  check("scan_code", bus.scan_code, cur_ev.code);
                  chk_pend = 1'b1;
               end
            end
         end
         prev_err = bus.frame_err;
      end
   end

   initial begin
      int          s0;
      logic [7:0]  seq[$];
      logic [10:0] f29;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // space make then break
      send_frame(8'h29, 1'b0);
      drain();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h29, 1'b0);
      drain();

      // down arrow, then space overrides, then space release re-exposes down
      send_frame(8'hE0, 1'b0);
      send_frame(8'h72, 1'b0);
      drain();
      send_frame(8'h29, 1'b0);
      drain();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h29, 1'b0);
      drain();
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h72, 1'b0);
      drain();

      // enter typematic: start must fire exactly twice
      s0 = n_start;
      repeat (3) send_frame(8'h5A, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h5A, 1'b0);
      send_frame(8'h5A, 1'b0);
      drain();
      check("start_count", 8'(n_start - s0), 8'd2);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h5A, 1'b0);
      drain();

      // bad parity: error strobe only, up stays low
      send_frame(8'h29, 1'b1);
      drain();
      check("parity_up", 8'(bus.up), 8'h00);

      // randomized key traffic with occasional parity errors
      for (int k = 0; k < 15; k++) begin
         seq.delete();
         case ($urandom_range(0, 8))
            0: seq = '{8'h29};
            1: seq = '{8'hF0, 8'h29};
            2: seq = '{8'hE0, 8'h75};
            3: seq = '{8'hE0, 8'hF0, 8'h75};
            4: seq = '{8'hE0, 8'h72};
            5: seq = '{8'hE0, 8'hF0, 8'h72};
            6: seq = '{8'h5A};
            7: seq = '{8'hF0, 8'h5A};
            default: begin
               case ($urandom_range(0, 3))
                  0: seq = '{8'h75};
                  1: seq = '{8'h72};
                  2: seq = '{8'hE1};
                  default: seq = '{8'h1C};
               endcase
            end
         endcase
         foreach (seq[j]) send_frame(seq[j], $urandom_range(0, 11) == 0);
         drain();
      end

      // reset mid-frame while up is held
      send_frame(8'h29, 1'b0);
      drain();
      check("pre_rst_up", 8'(bus.up), 8'h01);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_all_zero("mid_rst");
      repeat (4 * HALF) @(posedge clk);
      send_frame(8'h29, 1'b0);
      drain();
      check("post_rst_up", 8'(bus.up), 8'h01);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h29, 1'b0);
      drain();

      // partial frame, long silence, then a full 0x29
      f29 = {1'b1, 1'b0, 8'h29, 1'b0};
      for (int i = 0; i < 5; i++) send_bit(f29[i]);
`ifdef PS2_TIMEOUT_EN
      begin
         ev_t e;
         e.is_err = 1'b1;
         e.code   = 8'h00;
         e.up     = 1'b0;
         e.down   = 1'b0;
         e.start  = 1'b0;
         exp_q.push_back(e);
         pend.delete();
      end
`endif
      repeat (60000) @(posedge clk);
      send_frame(8'h29, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
